time_entry_ctrl: RTL and testbench

TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

---
 rtl/time_entry_ctrl.sv | 158 +++++++++++++++
 tb/tb_time_entry_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_ctrl.sv
// Time-entry controller: collects up to four keypad digits (HH:MM), validates
// them on a set_time/set_alarm strobe and hands the committed digits to the
// time counter or the alarm register with a one-cycle load pulse.
module time_entry_ctrl #(
   parameter int TIMEOUT_SEC = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       set_time,
   input  logic       set_alarm,
   output logic [3:0] new_current_time_ms_hr,
   output logic [3:0] new_current_time_ls_hr,
   output logic [3:0] new_current_time_ms_min,
   output logic [3:0] new_current_time_ls_min,
   output logic       load_new_c,
   output logic       load_new_a,
   output logic       entry_active,
   output logic       entry_error
);

   // Wide enough to hold TIMEOUT_SEC; at least one bit for degenerate settings.
   localparam int TW = (TIMEOUT_SEC < 1) ? 1 : $clog2(TIMEOUT_SEC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_COMMIT
   } state_e;

   state_e            state_q,        state_d;
   logic [3:0][3:0]   buf_q,          buf_d;          // [3]=ms_hr .. [0]=ls_min
   logic [TW-1:0]     timer_q,        timer_d;
   logic [15:0]       digits_q,       digits_d;
   logic              alarm_q,        alarm_d;        // pending commit targets alarm
   logic              load_c_q,       load_c_d;
   logic              load_a_q,       load_a_d;
   logic              err_q,          err_d;
   logic              entry_active_q, entry_active_d;

   logic key_is_digit;
   logic commit_req;
   logic buf_valid;

   assign key_is_digit = key_valid && (key_code <= 4'd9);
   assign commit_req   = set_time || set_alarm;

   // Buffer holds a legal 24-hour time (00:00 .. 23:59).
   assign buf_valid = (buf_q[3] <= 4'd2) &&
                      (buf_q[2] <= 4'd9) &&
                      !((buf_q[3] == 4'd2) && (buf_q[2] > 4'd3)) &&
                      (buf_q[1] <= 4'd5) &&
                      (buf_q[0] <= 4'd9);

   // Next-state logic: commit beats key, key beats the one-second tick.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
      state_d  = state_q;
      buf_d    = buf_q;
      timer_d  = timer_q;
      digits_d = digits_q;
      alarm_d  = alarm_q;
      load_c_d = 1'b0;
      load_a_d = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (key_is_digit) begin
               buf_d   = {12'h000, key_code};
               timer_d = '0;
               state_d = S_ENTRY;
            end
         end

         S_ENTRY: begin
            if (commit_req) begin
               if (buf_valid) begin
                  digits_d = buf_q;
                  alarm_d  = !set_time;          // set_time wins a tie
                  state_d  = S_COMMIT;
               end else begin
                  state_d  = S_IDLE;
                  buf_d    = '0;
                  timer_d  = '0;
                  err_d    = 1'b1;
               end
            end else if (key_is_digit) begin
               buf_d   = {buf_q[2:0], key_code};
               timer_d = '0;
            end else if (one_second) begin
               if (timer_q == TW'(TIMEOUT_SEC - 1)) begin
                  state_d = S_IDLE;
                  buf_d   = '0;
                  timer_d = '0;
                  err_d   = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
         end

         S_COMMIT: begin
            load_c_d = !alarm_q;
            load_a_d = alarm_q;
            state_d  = S_IDLE;
            buf_d    = '0;
            timer_d  = '0;
         end

         default: begin
            state_d = S_IDLE;
            buf_d   = '0;
            timer_d = '0;
         end
      endcase

      entry_active_d = (state_d == S_ENTRY);
   end

   // State, buffer, timer and every output are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         buf_q          <= '0;
         timer_q        <= '0;
         digits_q       <= '0;
         alarm_q        <= 1'b0;
         load_c_q       <= 1'b0;
         load_a_q       <= 1'b0;
         err_q          <= 1'b0;
         entry_active_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q        <= state_d;
         buf_q          <= buf_d;
         timer_q        <= timer_d;
         digits_q       <= digits_d;
         alarm_q        <= alarm_d;
         load_c_q       <= load_c_d;
         load_a_q       <= load_a_d;
         err_q          <= err_d;
         entry_active_q <= entry_active_d;
      end
   end

   assign new_current_time_ms_hr  = digits_q[15:12];
   assign new_current_time_ls_hr  = digits_q[11:8];
   assign new_current_time_ms_min = digits_q[7:4];
   assign new_current_time_ls_min = digits_q[3:0];
   assign load_new_c              = load_c_q;
   assign load_new_a              = load_a_q;
   assign entry_active            = entry_active_q;
   assign entry_error             = err_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: linear stimulus, immediate-assertion checks.
module tb_time_entry_ctrl;

   logic       clk;
   logic       reset;
   logic       one_second;
   logic       key_valid;
   logic [3:0] key_code;
   logic       set_time;
   logic       set_alarm;
   logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
   logic       load_new_c, load_new_a, entry_active, entry_error;

   int checks = 0;
   int errors = 0;

   time_entry_ctrl #(.TIMEOUT_SEC(10)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .one_second              (one_second),
      .key_valid               (key_valid),
      .key_code                (key_code),
      .set_time                (set_time),
      .set_alarm               (set_alarm),
      .new_current_time_ms_hr  (ms_hr),
      .new_current_time_ls_hr  (ls_hr),
      .new_current_time_ms_min (ms_min),
      .new_current_time_ls_min (ls_min),
      .load_new_c              (load_new_c),
      .load_new_a              (load_new_a),
      .entry_active            (entry_active),
      .entry_error             (entry_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {ms_hr, ls_hr, ms_min, ls_min};
   endfunction

   // Advance past the next rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_code  = d;
      tick();
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic keys4(input logic [15:0] v);
      key(v[15:12]);
      key(v[11:8]);
      key(v[7:4]);
      key(v[3:0]);
   endtask

   task automatic pulse_second();
      one_second = 1'b1;
      tick();
      one_second = 1'b0;
      tick();
   endtask

   task automatic strobe(input logic t, input logic a);
      set_time  = t;
      set_alarm = a;
      tick();
      set_time  = 1'b0;
      set_alarm = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      one_second = 1'b0;
      key_valid  = 1'b0;
      key_code   = 4'd0;
      set_time   = 1'b0;
      set_alarm  = 1'b0;

      // Reset state
      #2;
      check("rst_digits", digits(), 16'h0000);
      check("rst_loads", {14'd0, load_new_c, load_new_a}, 16'd0);
      check("rst_active_err", {14'd0, entry_active, entry_error}, 16'd0);
      tick();
      tick();
      reset = 1'b0;

      // Keys 2,3,5,9 then set_time
      key(4'd2);
      check("first_key_active", {15'd0, entry_active}, 16'd1);
      key(4'd3); key(4'd5); key(4'd9);
      strobe(1'b1, 1'b0);
      check("t1_digits_n1", digits(), 16'h2359);
      check("t1_no_load_yet", {14'd0, load_new_c, load_new_a}, 16'd0);
      check("t1_active_off", {15'd0, entry_active}, 16'd0);
      tick();
      check("t1_load_c", {14'd0, load_new_c, load_new_a}, 16'b10);
      tick();
      check("t1_load_end", {14'd0, load_new_c, load_new_a}, 16'd0);

      // Keys 2,4,0,0 then set_alarm: rejected
      keys4(16'h2400);
      strobe(1'b0, 1'b1);
      check("t2_err", {15'd0, entry_error}, 16'd1);
      check("t2_digits_hold", digits(), 16'h2359);
      check("t2_active", {15'd0, entry_active}, 16'd0);
      tick();
      check("t2_err_end", {15'd0, entry_error}, 16'd0);
      check("t2_no_load", {14'd0, load_new_c, load_new_a}, 16'd0);

      // Non-digit key in IDLE is ignored
      key(4'd12);
      check("idle_key12", {15'd0, entry_active}, 16'd0);

      // Key 1 then 10 one-second pulses (key 15 midway must not reset timer)
      key(4'd1);
      for (int i = 0; i < 5; i++) pulse_second();
      key(4'd15);
      for (int i = 0; i < 4; i++) pulse_second();
      check("t3_after9_active", {14'd0, entry_active, entry_error}, 16'b10);
      one_second = 1'b1;
      tick();
      one_second = 1'b0;
      check("t3_timeout", {14'd0, entry_active, entry_error}, 16'b01);
      tick();
      check("t3_err_end", {15'd0, entry_error}, 16'd0);
      strobe(1'b1, 1'b0);
      tick();
      check("t3_set_ignored", {14'd0, load_new_c, load_new_a}, 16'd0);
      check("t3_digits_hold", digits(), 16'h2359);

      // Keys 1,2,3,4,5 then set_time: oldest digit shifted out
      key(4'd1);
      keys4(16'h2345);
      strobe(1'b1, 1'b0);
      check("t4_digits", digits(), 16'h2345);
      tick();
      check("t4_load_c", {14'd0, load_new_c, load_new_a}, 16'b10);

      // Keys 0,7,3,0 then both strobes: set_time wins; key during COMMIT ignored
      tick();
      keys4(16'h0730);
      strobe(1'b1, 1'b1);
      check("t5_digits", digits(), 16'h0730);
      key(4'd5);
      check("t5_load_c_only", {14'd0, load_new_c, load_new_a}, 16'b10);
      check("t5_commit_key_ignored", {15'd0, entry_active}, 16'd0);
      tick();
      check("t5_still_idle", {15'd0, entry_active}, 16'd0);

      // Keys 1,2,3,4 then set_alarm with a key the same cycle: commit wins
      keys4(16'h1234);
      key_valid = 1'b1;
      key_code  = 4'd9;
      strobe(1'b0, 1'b1);
      key_valid = 1'b0;
      check("t6_digits", digits(), 16'h1234);
      check("t6_active", {15'd0, entry_active}, 16'd0);
      tick();
      check("t6_load_a", {14'd0, load_new_c, load_new_a}, 16'b01);
      tick();

      // Key and one_second same cycle: key wins, timer restarts
      key(4'd5);
      for (int i = 0; i < 9; i++) pulse_second();
      key_valid  = 1'b1;
      key_code   = 4'd6;
      one_second = 1'b1;
      tick();
      key_valid  = 1'b0;
      one_second = 1'b0;
      for (int i = 0; i < 9; i++) pulse_second();
      check("t7_timer_restarted", {14'd0, entry_active, entry_error}, 16'b10);
      one_second = 1'b1;
      tick();
      one_second = 1'b0;
      check("t7_timeout", {14'd0, entry_active, entry_error}, 16'b01);
      tick();

      // Minutes tens digit 6 is invalid
      keys4(16'h2360);
      strobe(1'b1, 1'b0);
      check("t8_err", {15'd0, entry_error}, 16'd1);
      check("t8_digits_hold", digits(), 16'h1234);
      tick();

      // 19:59 is valid, alarm load
      keys4(16'h1959);
      strobe(1'b0, 1'b1);
      check("t9_digits", digits(), 16'h1959);
      tick();
      check("t9_load_a", {14'd0, load_new_c, load_new_a}, 16'b01);
      tick();

      // Reset between third key and set_time
      key(4'd1); key(4'd2); key(4'd3);
      reset = 1'b1;
      #2;
      check("t10_rst_digits", digits(), 16'h0000);
      check("t10_rst_active", {15'd0, entry_active}, 16'd0);
      tick();
      reset = 1'b0;
      strobe(1'b1, 1'b0);
      check("t10_no_load_n1", {14'd0, load_new_c, load_new_a}, 16'd0);
      tick();
      check("t10_no_load_n2", {14'd0, load_new_c, load_new_a}, 16'd0);
      check("t10_digits_zero", digits(), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
